video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Programmable raster timing generator: produces HS/VS/DE/HBLANK/VBLANK and pixel
//  coordinates for a core's video output at CE_PIXEL rate. It is the source end of the
//  stream that the crop/aspect measurement logic consumes: that logic measures
//  hsize/vtot from VGA_DE/VGA_VS, and this block generates them. Geometry changes are
//  applied atomically at frame boundaries so downstream measurement never sees a torn frame.
// PARAMETERS
//  W        12      coordinate/geometry field width (matches 12-bit HDMI/ARX fields)
//  DEF_HACT 640     reset horizontal active; DEF_HFP 16, DEF_HSW 96, DEF_HBP 48
//  DEF_VACT 480     reset vertical active;   DEF_VFP 10, DEF_VSW 2,  DEF_VBP 33
// PORTS
//  CLK_VIDEO   in   1    video clock
//  RESET_N     in   1    async active-low reset
//  CE_PIXEL    in   1    pixel enable; all raster state advances only when high
//  CFG_HACT,CFG_HFP,CFG_HSW,CFG_HBP  in  W each  requested horizontal geometry
//  CFG_VACT,CFG_VFP,CFG_VSW,CFG_VBP  in  W each  requested vertical geometry (lines)
//  CFG_HSPOL,CFG_VSPOL  in 1  sync polarity, 1 = active-high
//  CFG_LOAD    in   1    1-clk strobe: capture CFG_* into pending shadow
//  CFG_PENDING out  1    shadow captured, not yet applied
//  CFG_ERR     out  1    sticky: last CFG_LOAD rejected; cleared by next accepted load
//  VGA_HS,VGA_VS  out 1  syncs at programmed polarity
//  VGA_DE      out  1    active video
//  HBLANK,VBLANK out 1   blanking flags
//  HCOUNT,VCOUNT out W   coordinate of the pixel currently presented
//  FRAME_START out  1    1-clk pulse on the CE where (0,0) is presented
// BEHAVIOUR
//  - Reset: internal counters = (HTOT-1,VTOT-1) of DEF_*; shadow/active cfg = DEF_*,
//    HSPOL=VSPOL=0; outputs: VGA_DE=0, HBLANK=VBLANK=1, syncs at inactive level
//    (high for pol 0), HCOUNT=VCOUNT=0, FRAME_START=0, CFG_PENDING=0, CFG_ERR=0.
//    First CE after reset presents (0,0).
//  - Line order: active, front porch, sync, back porch. HTOT=HACT+HFP+HSW+HBP, same for V.
//  - On CE: h<=h+1; at h==HTOT-1, h<=0 and v<=v+1 (v wraps at VTOT-1). Outputs are
//    registered decodes of the new (h,v) and update on the same edge: latency 0 CE
//    between HCOUNT/VCOUNT and the flags.
//    DE = h<HACT && v<VACT; HBLANK = h>=HACT; VBLANK = v>=VACT;
//    HS active for h in [HACT+HFP, HACT+HFP+HSW); VS active for v in
//    [VACT+VFP, VACT+VFP+VSW), switching at h==0 (line-aligned, not pixel-aligned).
//  - Without CE all outputs hold; FRAME_START is a single CLK_VIDEO pulse, not CE-stretched.
//  - Config: CFG_LOAD validates combinationally. Reject (CFG_ERR=1, shadow unchanged,
//    CFG_PENDING unchanged) if HACT==0, HSW==0, VACT==0, VSW==0, or HTOT/VTOT (computed
//    W+2 bits wide) > 2^W-1. Otherwise shadow<=CFG_*, CFG_PENDING=1, CFG_ERR=0.
//  - Apply: on the CE that wraps to (0,0) with CFG_PENDING=1, active<=shadow and
//    CFG_PENDING<=0; that (0,0) decode already uses the new geometry and polarity.
//  - CFG_LOAD on the same clock as the apply wrap: the old shadow is applied, the new
//    value is captured, and CFG_PENDING stays 1 for the next frame.
//  - Repeated loads before a wrap: last accepted load wins.
//  - Async reset mid-frame: all state returns to reset values immediately; a pending
//    cfg is discarded.
// STRUCTURE
//  - Shared package/include: W, the DEF_* geometry, and the sync-polarity encoding, so
//    the measurement side and the testbench use the same values.
//  - Sub-module video_timing_axis (count, total, sync-start/end compare, wrap out, blank,
//    sync) instantiated twice. H advances on CE; V advances on H wrap. Top level holds
//    the shadow/active config registers and validation.
// TESTING
//  1 Reset, default cfg: HTOT=800, VTOT=525; DE high for 640 CEs per line on 480 lines;
//    HS low at h 656..751; VS low on lines 490..491; FRAME_START every 420000 CEs.
//  2 CE_PIXEL at 1/4 duty: identical CE-indexed waveform to test 1; outputs frozen
//    between CEs; FRAME_START exactly 1 clk wide.
//  3 Mid-frame CFG_LOAD of 320x240 (HFP 8, HSW 32, HBP 40; VFP 3, VSW 4, VBP 15):
//    CFG_PENDING=1; the current frame completes at 800x525; next frame HTOT=400, VTOT=262.
//  4 CFG_LOAD with HACT=0, then with HACT=4000, HFP=200: CFG_ERR=1 each time, geometry
//    unchanged; a valid load then clears CFG_ERR.
//  5 CFG_LOAD coincident with the wrap CE while pending: old shadow applied, new one
//    pending, applied one frame later.
//  6 Polarity flip to HSPOL=VSPOL=1 plus RESET_N pulsed at h=300, v=100: syncs reset to
//    the default inactive level; the pending cfg is lost; the first CE presents (0,0).

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// rtl/video_timing_gen_pkg.sv - shared raster geometry width, reset geometry and sync polarity encoding
package video_timing_gen_pkg;

    localparam int W = 12;

    localparam logic [W-1:0] DEF_HACT = 12'd640;
    localparam logic [W-1:0] DEF_HFP  = 12'd16;
    localparam logic [W-1:0] DEF_HSW  = 12'd96;
    localparam logic [W-1:0] DEF_HBP  = 12'd48;
    localparam logic [W-1:0] DEF_VACT = 12'd480;
    localparam logic [W-1:0] DEF_VFP  = 12'd10;
    localparam logic [W-1:0] DEF_VSW  = 12'd2;
    localparam logic [W-1:0] DEF_VBP  = 12'd33;

    // Polarity bit: 1 means the sync pulse is driven high while active.
    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;
    localparam logic DEF_SYNC_POL     = SYNC_ACTIVE_LOW;

    // Last counter value of the default line/frame; counters park here in reset
    // so the first pixel enable wraps straight to (0,0).
    localparam logic [W-1:0] DEF_H_LAST = DEF_HACT + DEF_HFP + DEF_HSW + DEF_HBP - 1'b1;
    localparam logic [W-1:0] DEF_V_LAST = DEF_VACT + DEF_VFP + DEF_VSW + DEF_VBP - 1'b1;

    typedef struct packed {
        logic [W-1:0] act;
        logic [W-1:0] fp;
        logic [W-1:0] sw;
        logic [W-1:0] bp;
        logic         pol;
    } axis_cfg_t;

    localparam axis_cfg_t DEF_H_CFG = '{act: DEF_HACT, fp: DEF_HFP, sw: DEF_HSW, bp: DEF_HBP, pol: DEF_SYNC_POL};
    localparam axis_cfg_t DEF_V_CFG = '{act: DEF_VACT, fp: DEF_VFP, sw: DEF_VSW, bp: DEF_VBP, pol: DEF_SYNC_POL};

    // Two guard bits so an oversized request cannot wrap back into range.
    function automatic logic [W+1:0] axis_total(input axis_cfg_t c);
        return {2'b00, c.act} + {2'b00, c.fp} + {2'b00, c.sw} + {2'b00, c.bp};
    endfunction

    function automatic logic sync_level(input logic pol, input logic on);
        return pol ? on : ~on;
    endfunction

endpackage

// File: rtl/video_timing_axis.sv
// rtl/video_timing_axis.sv - one raster axis: position counter plus registered active/blank/sync decode
module video_timing_axis
    import video_timing_gen_pkg::*;
#(
    parameter logic [W-1:0] RST_CNT = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv,
    input  logic [W+1:0] cur_tot,
    input  logic [W-1:0] nxt_act,
    input  logic [W-1:0] nxt_fp,
    input  logic [W-1:0] nxt_sw,
    input  logic         nxt_pol,
    output logic         wrap,
    output logic [W-1:0] count,
    output logic         active,
    output logic         blank,
    output logic         sync
);

    localparam logic [W+1:0] ONE = (W+2)'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_nxt;
    logic [W+1:0] cnt_ext;
    logic [W+1:0] sync_start;
    logic [W+1:0] sync_end;
    logic         act_nxt;
    logic         sync_on;

    // Wrap is judged against the geometry in force; the decode of the new
    // position uses the geometry that will be in force after this edge.
    assign wrap       = ({2'b00, cnt_q} + ONE) == cur_tot;
    assign cnt_nxt    = wrap ? '0 : cnt_q + 1'b1;
    assign cnt_ext    = {2'b00, cnt_nxt};
    assign sync_start = {2'b00, nxt_act} + {2'b00, nxt_fp};
    assign sync_end   = sync_start + {2'b00, nxt_sw};
    assign act_nxt    = cnt_ext < {2'b00, nxt_act};
    assign sync_on    = (cnt_ext >= sync_start) && (cnt_ext < sync_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= RST_CNT;
            count  <= '0;
            active <= 1'b0;
            blank  <= 1'b1;
            sync   <= sync_level(DEF_SYNC_POL, 1'b0);
        end else if (adv) begin
            cnt_q  <= cnt_nxt;
            count  <= cnt_nxt;
            active <= act_nxt;
            blank  <= ~act_nxt;
            sync   <= sync_level(nxt_pol, sync_on);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - programmable raster timing generator with frame-atomic geometry updates
module video_timing_gen
    import video_timing_gen_pkg::*;
(
    input  logic         CLK_VIDEO,
    input  logic         RESET_N,
    input  logic         CE_PIXEL,
    input  logic [W-1:0] CFG_HACT,
    input  logic [W-1:0] CFG_HFP,
    input  logic [W-1:0] CFG_HSW,
    input  logic [W-1:0] CFG_HBP,
    input  logic [W-1:0] CFG_VACT,
    input  logic [W-1:0] CFG_VFP,
    input  logic [W-1:0] CFG_VSW,
    input  logic [W-1:0] CFG_VBP,
    input  logic         CFG_HSPOL,
    input  logic         CFG_VSPOL,
    input  logic         CFG_LOAD,
    output logic         CFG_PENDING,
    output logic         CFG_ERR,
    output logic         VGA_HS,
    output logic         VGA_VS,
    output logic         VGA_DE,
    output logic         HBLANK,
    output logic         VBLANK,
    output logic [W-1:0] HCOUNT,
    output logic [W-1:0] VCOUNT,
    output logic         FRAME_START
);

    localparam logic [W+1:0] TOT_MAX = {2'b00, {W{1'b1}}};

    axis_cfg_t h_req;
    axis_cfg_t v_req;
    axis_cfg_t h_shd;
    axis_cfg_t v_shd;
    axis_cfg_t h_cur;
    axis_cfg_t v_cur;
    logic      cfg_ok;
    logic      h_wrap;
    logic      v_wrap;
    logic      frame_wrap;
    logic      apply;
    logic      h_active;
    logic      v_active;

    assign h_req = '{act: CFG_HACT, fp: CFG_HFP, sw: CFG_HSW, bp: CFG_HBP, pol: CFG_HSPOL};
    assign v_req = '{act: CFG_VACT, fp: CFG_VFP, sw: CFG_VSW, bp: CFG_VBP, pol: CFG_VSPOL};

    assign cfg_ok = (CFG_HACT != '0) && (CFG_HSW != '0) &&
                    (CFG_VACT != '0) && (CFG_VSW != '0) &&
                    (axis_total(h_req) <= TOT_MAX) && (axis_total(v_req) <= TOT_MAX);

    assign frame_wrap = CE_PIXEL && h_wrap && v_wrap;
    assign apply      = frame_wrap && CFG_PENDING;

    video_timing_axis #(
        .RST_CNT (DEF_H_LAST)
    ) u_h_axis (
        .clk     (CLK_VIDEO),
        .rst_n   (RESET_N),
        .adv     (CE_PIXEL),
        .cur_tot (axis_total(h_cur)),
        .nxt_act (apply ? h_shd.act : h_cur.act),
        .nxt_fp  (apply ? h_shd.fp  : h_cur.fp),
        .nxt_sw  (apply ? h_shd.sw  : h_cur.sw),
        .nxt_pol (apply ? h_shd.pol : h_cur.pol),
        .wrap    (h_wrap),
        .count   (HCOUNT),
        .active  (h_active),
        .blank   (HBLANK),
        .sync    (VGA_HS)
    );

    // Vertical axis steps once per line, so VS changes only where h returns to 0.
    video_timing_axis #(
        .RST_CNT (DEF_V_LAST)
    ) u_v_axis (
        .clk     (CLK_VIDEO),
        .rst_n   (RESET_N),
        .adv     (CE_PIXEL && h_wrap),
        .cur_tot (axis_total(v_cur)),
        .nxt_act (apply ? v_shd.act : v_cur.act),
        .nxt_fp  (apply ? v_shd.fp  : v_cur.fp),
        .nxt_sw  (apply ? v_shd.sw  : v_cur.sw),
        .nxt_pol (apply ? v_shd.pol : v_cur.pol),
        .wrap    (v_wrap),
        .count   (VCOUNT),
        .active  (v_active),
        .blank   (VBLANK),
        .sync    (VGA_VS)
    );

    assign VGA_DE = h_active && v_active;

    // Apply happens before capture so a load on the wrap clock queues for the next frame.
    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cur       <= DEF_H_CFG;
            v_cur       <= DEF_V_CFG;
            h_shd       <= DEF_H_CFG;
            v_shd       <= DEF_V_CFG;
            CFG_PENDING <= 1'b0;
            CFG_ERR     <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            FRAME_START <= frame_wrap;
            if (apply) begin
                h_cur       <= h_shd;
                v_cur       <= v_shd;
                CFG_PENDING <= 1'b0;
            end
            if (CFG_LOAD) begin
                if (cfg_ok) begin
                    h_shd       <= h_req;
                    v_shd       <= v_req;
                    CFG_PENDING <= 1'b1;
                    CFG_ERR     <= 1'b0;
                end else begin
                    CFG_ERR <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen against a raster model
module tb_video_timing_gen;
    import video_timing_gen_pkg::*;

    typedef struct {
        int hact, hfp, hsw, hbp, vact, vfp, vsw, vbp;
        bit hpol, vpol;
    } geom_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic         ce    = 1'b0;
    logic         load  = 1'b0;
    logic [W-1:0] hact, hfp, hsw, hbp, vact, vfp, vsw, vbp;
    logic         hpol, vpol;
    logic         pend, err, hs, vs, de, hb, vb, fs;
    logic [W-1:0] hc, vc;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    video_timing_gen dut (
        .CLK_VIDEO(clk), .RESET_N(rst_n), .CE_PIXEL(ce),
        .CFG_HACT(hact), .CFG_HFP(hfp), .CFG_HSW(hsw), .CFG_HBP(hbp),
        .CFG_VACT(vact), .CFG_VFP(vfp), .CFG_VSW(vsw), .CFG_VBP(vbp),
        .CFG_HSPOL(hpol), .CFG_VSPOL(vpol), .CFG_LOAD(load),
        .CFG_PENDING(pend), .CFG_ERR(err),
        .VGA_HS(hs), .VGA_VS(vs), .VGA_DE(de), .HBLANK(hb), .VBLANK(vb),
        .HCOUNT(hc), .VCOUNT(vc), .FRAME_START(fs)
    );

    function automatic geom_t mk(int ha, int hf, int hw, int hbk, int va, int vf, int vw, int vbk, bit hp, bit vp);
        geom_t g;
        g.hact = ha; g.hfp = hf; g.hsw = hw; g.hbp = hbk;
        g.vact = va; g.vfp = vf; g.vsw = vw; g.vbp = vbk;
        g.hpol = hp; g.vpol = vp;
        return g;
    endfunction

    function automatic int htot(geom_t g); return g.hact + g.hfp + g.hsw + g.hbp; endfunction
    function automatic int vtot(geom_t g); return g.vact + g.vfp + g.vsw + g.vbp; endfunction

    function automatic bit req_ok(geom_t g);
        return g.hact > 0 && g.hsw > 0 && g.vact > 0 && g.vsw > 0 && htot(g) <= 4095 && vtot(g) <= 4095;
    endfunction

    function automatic geom_t cur_req();
        return mk(int'(hact), int'(hfp), int'(hsw), int'(hbp), int'(vact), int'(vfp), int'(vsw), int'(vbp), hpol, vpol);
    endfunction

    geom_t g_def, g_a, g_b, g_c, g_tmp;

    // Model: position of the presented pixel plus active/shadow geometry.
    geom_t m_act, m_shd, m_rq;
    bit    m_pend = 0, m_err = 0, m_run = 0, m_fs = 0;
    int    m_h = 0, m_v = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = g_def; m_shd = g_def; m_pend = 0; m_err = 0;
            m_run = 0; m_fs = 0; m_h = 0; m_v = 0;
        end else begin
            m_rq = cur_req();
            m_fs = 0;
            if (ce) begin
                if (!m_run) begin
                    m_run = 1; m_h = 0; m_v = 0;
                end else begin
                    m_h = m_h + 1;
                    if (m_h == htot(m_act)) begin
                        m_h = 0;
                        m_v = (m_v + 1 == vtot(m_act)) ? 0 : m_v + 1;
                    end
                end
                if (m_h == 0 && m_v == 0) begin
                    m_fs = 1;
                    if (m_pend) begin m_act = m_shd; m_pend = 0; end
                end
            end
            if (load) begin
                if (req_ok(m_rq)) begin m_shd = m_rq; m_pend = 1; m_err = 0; end
                else m_err = 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            bit e_de, e_hb, e_vb, e_hs, e_vs;
            int sh, sv;
            if (m_run) begin
                sh   = m_act.hact + m_act.hfp;
                sv   = m_act.vact + m_act.vfp;
                e_de = m_h < m_act.hact && m_v < m_act.vact;
                e_hb = m_h >= m_act.hact;
                e_vb = m_v >= m_act.vact;
                e_hs = (m_h >= sh && m_h < sh + m_act.hsw) ? m_act.hpol : !m_act.hpol;
                e_vs = (m_v >= sv && m_v < sv + m_act.vsw) ? m_act.vpol : !m_act.vpol;
            end else begin
                e_de = 0; e_hb = 1; e_vb = 1; e_hs = 1; e_vs = 1;
            end
            chk("de", de, e_de);
            chk("hblank", hb, e_hb);
            chk("vblank", vb, e_vb);
            chk("hs", hs, e_hs);
            chk("vs", vs, e_vs);
            chk("hcount", hc, m_run ? m_h : 0);
            chk("vcount", vc, m_run ? m_v : 0);
            chk("frame_start", fs, m_fs);
            chk("cfg_pending", pend, m_pend);
            chk("cfg_err", err, m_err);
        end
    end

    task automatic drive_cfg(input geom_t g);
        hact = W'(g.hact); hfp = W'(g.hfp); hsw = W'(g.hsw); hbp = W'(g.hbp);
        vact = W'(g.vact); vfp = W'(g.vfp); vsw = W'(g.vsw); vbp = W'(g.vbp);
        hpol = g.hpol; vpol = g.vpol;
    endtask

    task automatic cyc(input bit c, input bit l);
        ce = c; load = l;
        @(posedge clk);
        #1;
        ce = 0; load = 0;
    endtask

    task automatic frame_len(output int n);
        n = 0;
        do begin cyc(1, 0); n++; end while (!fs && n < 1000);
    endtask

    task automatic rst_pulse(input string tag);
        #2 rst_n = 0;
        #1;
        chk({tag, "_hs"}, hs, 1);
        chk({tag, "_vs"}, vs, 1);
        chk({tag, "_de"}, de, 0);
        chk({tag, "_hb"}, hb, 1);
        chk({tag, "_hc"}, hc, 0);
        chk({tag, "_vc"}, vc, 0);
        chk({tag, "_pend"}, pend, 0);
        cyc(0, 0);
        cyc(0, 0);
        rst_n = 1;
    endtask

    initial begin
        int n, de_n, hs_n, fs_n, k;
        g_def = mk(640, 16, 96, 48, 480, 10, 2, 33, 0, 0);
        g_a   = mk(10, 2, 3, 1, 6, 1, 2, 1, 0, 0);
        g_b   = mk(8, 1, 2, 1, 4, 2, 1, 1, 1, 0);
        g_c   = mk(6, 1, 1, 2, 5, 1, 1, 1, 1, 1);
        m_act = g_def; m_shd = g_def;
        drive_cfg(g_def);
        repeat (3) cyc(0, 0);
        rst_n = 1;
        chk_en = 1;
        cyc(0, 0);
        chk("rst_de", de, 0);
        chk("rst_hblank", hb, 1);
        chk("rst_vblank", vb, 1);
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 1);
        chk("rst_hcount", hc, 0);
        chk("rst_fs", fs, 0);
        chk("rst_pend", pend, 0);
        chk("rst_err", err, 0);

        // Default 800-pixel line at full rate.
        cyc(1, 0);
        chk("t1_first_fs", fs, 1);
        chk("t1_first_de", de, 1);
        de_n = de; hs_n = !hs;
        for (int i = 1; i < 800; i++) begin
            cyc(1, 0);
            de_n += de; hs_n += !hs;
            if (i == 655) chk("t1_hs_655", hs, 1);
            if (i == 656) chk("t1_hs_656", hs, 0);
            if (i == 752) chk("t1_hs_752", hs, 1);
        end
        chk("t1_de_per_line", de_n, 640);
        chk("t1_hs_low_per_line", hs_n, 96);
        chk("t1_line_end", hc, 799);
        cyc(1, 0);
        chk("t1_line1_v", vc, 1);
        chk("t1_line1_h", hc, 0);
        repeat (900) cyc(1, 0);
        repeat (200) begin cyc(1, 0); repeat (3) cyc(0, 0); end

        // Small geometry A, applied on the first CE after reset, run at 1/4 duty.
        rst_pulse("rsta");
        drive_cfg(g_a);
        cyc(0, 1);
        chk("a_pend", pend, 1);
        cyc(1, 0);
        chk("a_fs", fs, 1);
        chk("a_pend_clr", pend, 0);
        fs_n = 0;
        repeat (320) begin
            cyc(1, 0); fs_n += fs;
            repeat (3) begin cyc(0, 0); fs_n += fs; end
        end
        chk("t2_fs_clocks", fs_n, 2);

        // Mid-frame load: frame in progress finishes at A, then B.
        repeat (79) cyc(1, 0);
        drive_cfg(g_b);
        cyc(1, 1);
        chk("t3_pend", pend, 1);
        frame_len(n);
        chk("t3_old_rest", n, 80);
        chk("t3_pend_clr", pend, 0);
        frame_len(n);
        chk("t3_new_frame", n, 96);

        // Rejected loads, boundary total 4095, last load wins.
        g_tmp = g_b; g_tmp.hact = 0;
        drive_cfg(g_tmp); cyc(1, 1);
        chk("t4_hact0_err", err, 1);
        chk("t4_hact0_pend", pend, 0);
        g_tmp = g_b; g_tmp.hact = 4000; g_tmp.hfp = 200;
        drive_cfg(g_tmp); cyc(1, 1);
        chk("t4_big_err", err, 1);
        chk("t4_big_pend", pend, 0);
        g_tmp = g_b; g_tmp.hact = 4092; g_tmp.hfp = 1; g_tmp.hsw = 1; g_tmp.hbp = 1;
        drive_cfg(g_tmp); cyc(1, 1);
        chk("t4_edge_err", err, 0);
        chk("t4_edge_pend", pend, 1);
        drive_cfg(g_c); cyc(1, 1);
        chk("t4_c_err", err, 0);
        frame_len(n);
        chk("t4_b_rest", n, 92);
        frame_len(n);
        chk("t4_c_frame", n, 80);

        // Load coincident with the apply wrap.
        drive_cfg(g_a); cyc(0, 1);
        k = 0;
        while (!(m_h == htot(m_act) - 1 && m_v == vtot(m_act) - 1) && k < 1000) begin
            cyc(1, 0); k++;
        end
        drive_cfg(g_b); cyc(1, 1);
        chk("t5_fs", fs, 1);
        chk("t5_pend", pend, 1);
        frame_len(n);
        chk("t5_a_frame", n, 160);
        chk("t5_pend_clr", pend, 0);
        frame_len(n);
        chk("t5_b_frame", n, 96);

        // Pending polarity flip discarded by a mid-frame reset.
        drive_cfg(g_c); cyc(0, 1);
        chk("t6_pend", pend, 1);
        repeat (29) cyc(1, 0);
        chk("t6_hs_pre", hs, 0);
        rst_pulse("rst6");
        cyc(1, 0);
        chk("t6_fs", fs, 1);
        chk("t6_hc0", hc, 0);
        chk("t6_vc0", vc, 0);
        repeat (799) cyc(1, 0);
        chk("t6_line_end", hc, 799);
        chk("t6_vc", vc, 0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
